ex_mem_latch: RTL and testbench

- Pipeline register between the execute stage and the memory stage.
- Captures the ALU result, the store data, memory control and writeback control at each clock edge, and presents them to the memory stage one cycle later.
- Supports stall (hold), flush (bubble insert) and a sticky halt that freezes the latch once a halt instruction reaches memory.
- Keeps a saturating count of retired-into-memory instructions for debug.

---
 rtl/ex_mem_latch.sv | 92 +++++++++
 tb/tb_ex_mem_latch.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_latch.sv
// rtl/ex_mem_latch.sv - EX/MEM pipeline register with stall, flush, sticky halt and instruction counter
// Optional store-data bypass from writeback is enabled with `define EX_MEM_BYPASS_EN.
module ex_mem_latch #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] aluOut_in,
  input  logic [DATA_W-1:0] writeData_in,
  input  logic              memWrite_in,
  input  logic              memRead_in,
  input  logic              regWrite_in,
  input  logic [REG_W-1:0]  writeReg_in,
  input  logic              halt_in,
`ifdef EX_MEM_BYPASS_EN
  input  logic              wb_regWrite,
  input  logic [REG_W-1:0]  wb_writeReg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [REG_W-1:0]  storeReg_in,
`endif
  output logic              valid_out,
  output logic [DATA_W-1:0] aluOut,
  output logic [DATA_W-1:0] writeData,
  output logic              memWrite,
  output logic              memRead,
  output logic              regWrite,
  output logic [REG_W-1:0]  writeReg,
  output logic              halt,
  output logic              conflict,
  output logic [CNT_W-1:0]  instr_cnt
);

  logic [DATA_W-1:0] store_data;
  logic              do_load;

  // A store whose source register is being written back this cycle takes the fresh value.
  always_comb begin
    store_data = writeData_in;
`ifdef EX_MEM_BYPASS_EN
    if (memWrite_in && wb_regWrite && (wb_writeReg == storeReg_in))
      store_data = wb_data;
`endif
  end

  assign do_load = !flush && valid_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      aluOut    <= '0;
      writeData <= '0;
      memWrite  <= 1'b0;
      memRead   <= 1'b0;
      regWrite  <= 1'b0;
      writeReg  <= '0;
      halt      <= 1'b0;
      conflict  <= 1'b0;
      instr_cnt <= '0;
    end else if (!halt && !stall) begin
      if (do_load) begin
        valid_out <= 1'b1;
        aluOut    <= aluOut_in;
        writeData <= store_data;
        memWrite  <= memWrite_in;
        // Simultaneous read and write: the store wins and the clash is flagged.
        memRead   <= memRead_in && !memWrite_in;
        regWrite  <= regWrite_in;
        writeReg  <= writeReg_in;
        halt      <= halt_in;
        conflict  <= memRead_in && memWrite_in;
        if (instr_cnt != {CNT_W{1'b1}})
          instr_cnt <= instr_cnt + 1'b1;
      end else begin
        valid_out <= 1'b0;
        aluOut    <= '0;
        writeData <= '0;
        memWrite  <= 1'b0;
        memRead   <= 1'b0;
        regWrite  <= 1'b0;
        writeReg  <= '0;
        halt      <= 1'b0;
        conflict  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_latch.sv
// tb/tb_ex_mem_latch.sv - self-checking bench for ex_mem_latch (vector table plus scoreboard queue)
module tb_ex_mem_latch;

  typedef struct packed {
    logic        v;
    logic [15:0] alu;
    logic [15:0] wd;
    logic        mw, mr, rw;
    logic [2:0]  wr;
    logic        h, c;
    logic [15:0] cnt;
  } exp_t;

  typedef struct packed {
    logic        st, fl, v;
    logic [15:0] alu;
    logic [15:0] wd;
    logic        mw, mr, rw;
    logic [2:0]  wr;
    logic        h;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_in;
  logic [15:0] aluOut_in, writeData_in;
  logic        memWrite_in, memRead_in, regWrite_in, halt_in;
  logic [2:0]  writeReg_in;
`ifdef EX_MEM_BYPASS_EN
  logic        wb_regWrite;
  logic [2:0]  wb_writeReg, storeReg_in;
  logic [15:0] wb_data;
`endif
  logic        valid_out, memWrite, memRead, regWrite, halt, conflict;
  logic [15:0] aluOut, writeData, instr_cnt;
  logic [2:0]  writeReg;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[16];
  exp_t zero_e;
  exp_t hold_e;

  ex_mem_latch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .aluOut_in(aluOut_in), .writeData_in(writeData_in), .memWrite_in(memWrite_in),
    .memRead_in(memRead_in), .regWrite_in(regWrite_in), .writeReg_in(writeReg_in),
    .halt_in(halt_in),
`ifdef EX_MEM_BYPASS_EN
    .wb_regWrite(wb_regWrite), .wb_writeReg(wb_writeReg), .wb_data(wb_data),
    .storeReg_in(storeReg_in),
`endif
    .valid_out(valid_out), .aluOut(aluOut), .writeData(writeData), .memWrite(memWrite),
    .memRead(memRead), .regWrite(regWrite), .writeReg(writeReg), .halt(halt),
    .conflict(conflict), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    stall = t.st; flush = t.fl; valid_in = t.v;
    aluOut_in = t.alu; writeData_in = t.wd;
    memWrite_in = t.mw; memRead_in = t.mr; regWrite_in = t.rw;
    writeReg_in = t.wr; halt_in = t.h;
  endtask

  // Pop the oldest expectation and compare it with what the DUT presents now.
  task automatic pop_cmp(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, " valid_out"}, 32'(valid_out), 32'(e.v));
    chk({tag, " aluOut"},    32'(aluOut),    32'(e.alu));
    chk({tag, " writeData"}, 32'(writeData), 32'(e.wd));
    chk({tag, " memWrite"},  32'(memWrite),  32'(e.mw));
    chk({tag, " memRead"},   32'(memRead),   32'(e.mr));
    chk({tag, " regWrite"},  32'(regWrite),  32'(e.rw));
    chk({tag, " writeReg"},  32'(writeReg),  32'(e.wr));
    chk({tag, " halt"},      32'(halt),      32'(e.h));
    chk({tag, " conflict"},  32'(conflict),  32'(e.c));
    chk({tag, " instr_cnt"}, 32'(instr_cnt), 32'(e.cnt));
  endtask

  task automatic step_vec(input vec_t t, input exp_t e, input string tag);
    drive(t);
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_cmp(tag);
  endtask

  initial begin
    vec_t idle;
    exp_t e;
    idle   = '0;
    zero_e = '0;
    hold_e = '{1'b1, 16'h1234, 16'hBEEF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'd1};

    vecs[0]  = '{1'b0, 1'b0, 1'b1, 16'h1234, 16'hBEEF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, hold_e};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, hold_e};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 16'h5A5A, 16'hA5A5, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, hold_e};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, hold_e};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'h3333, 16'h4444, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0,
                 '{1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'd1}};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0,
                 '{1'b1, 16'h0040, 16'h0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 16'd2}};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h0050, 16'h00A5, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0,
                 '{1'b1, 16'h0050, 16'h00A5, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 16'd3}};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b1, 3'd7, 1'b1,
                 '{1'b1, 16'h0050, 16'h00A5, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 16'd3}};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h9999, 16'h8888, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1,
                 '{1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'd3}};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0060, 16'h0007, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0,
                 '{1'b1, 16'h0060, 16'h0007, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 16'd4}};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 16'h0070, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1,
                 '{1'b1, 16'h0070, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 16'd5}};
    for (int i = 11; i < 16; i++)
      vecs[i] = '{1'b0, 1'(i % 2), 1'b1, 16'(16'h0100 * i), 16'(16'h0011 * i),
                  1'b1, 1'(i % 3 == 0), 1'b1, 3'(i), 1'b0, vecs[10].e};

    drive(idle);
`ifdef EX_MEM_BYPASS_EN
    wb_regWrite = 1'b0; wb_writeReg = '0; wb_data = '0; storeReg_in = '0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.push_back(zero_e);
    pop_cmp("reset");
    step_vec(idle, zero_e, "idle after reset");

    for (int i = 0; i < 16; i++)
      step_vec(vecs[i], vecs[i].e, $sformatf("vec%0d", i));

    // Reset must override the frozen state even with a valid instruction presented.
    rst = 1'b1;
    step_vec(vecs[0], zero_e, "reset while frozen");
    rst = 1'b0;
    e = hold_e;
    step_vec(vecs[0], e, "load after unfreeze");

    // Counter saturation: 65535 loads reach the ceiling, one more must not wrap.
    rst = 1'b1;
    step_vec(idle, zero_e, "reset before saturation");
    rst = 1'b0;
    drive(vecs[9]);
    repeat (65534) @(posedge clk);
    #1;
    e = vecs[9].e;
    e.cnt = 16'hFFFE;
    sb.push_back(e);
    pop_cmp("cnt 65534");
    e.cnt = 16'hFFFF;
    step_vec(vecs[9], e, "cnt 65535");
    step_vec(vecs[9], e, "cnt saturated");

`ifdef EX_MEM_BYPASS_EN
    rst = 1'b1;
    step_vec(idle, zero_e, "reset before bypass");
    rst = 1'b0;
    storeReg_in = 3'd3; wb_regWrite = 1'b1; wb_writeReg = 3'd3; wb_data = 16'h00AA;
    e = '{1'b1, 16'h0020, 16'h00AA, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'd1};
    step_vec('{1'b0, 1'b0, 1'b1, 16'h0020, 16'h5555, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, e}, e,
             "bypass hit");
    wb_writeReg = 3'd4;
    e = '{1'b1, 16'h0020, 16'h5555, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'd2};
    step_vec('{1'b0, 1'b0, 1'b1, 16'h0020, 16'h5555, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, e}, e,
             "bypass miss");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
